// File: rtl/dbus_arbiter_pkg.sv
// dbus_arbiter_pkg: shared bus types, FSM states and requester indices for dbus_arbiter.
package dbus_arbiter_pkg;
  localparam int DBUS_ARB_NREQ = 3;
  localparam int ARB_MEM = 0;
  localparam int ARB_PTW = 1;
  localparam int ARB_AUX = 2;
  // MSIZE8 encodes as zero so an all-zero request is a full-width access
  typedef enum logic [1:0] {
    MSIZE8 = 2'd0,
    MSIZE1 = 2'd1,
    MSIZE2 = 2'd2,
    MSIZE4 = 2'd3
  } msize_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [63:0] data;
    logic [7:0]  strobe;
  } dbus_req_t;
  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_HOLD} arb_state_t;
  function automatic int wrap_inc(int i, int n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/dbus_arbiter_if.sv
// dbus_arbiter_if: requester-side and shared-bus-side signals of the data-bus arbiter.
interface dbus_arbiter_if import dbus_arbiter_pkg::*; #(
  parameter int NREQ = DBUS_ARB_NREQ
);
  localparam int IDX_W = $clog2(NREQ);
  dbus_req_t        ireqs [NREQ];
  logic [NREQ-1:0]  ilock;
  dbus_resp_t       oresps [NREQ];
  dbus_req_t        oreq;
  dbus_resp_t       iresp;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  modport slave (
    input  ireqs, ilock, iresp,
    output oresps, oreq, grant_idx, busy
  );
  modport master (
    output ireqs, ilock, iresp,
    input  oresps, oreq, grant_idx, busy
  );
endinterface

// File: rtl/dbus_arb_pick.sv
// dbus_arb_pick: combinational winner picker; rotates the valid vector by the start pointer then priority-encodes.
module dbus_arb_pick #(
  parameter int NREQ = 3,
  parameter bit RR = 1'b0,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_valid,
  input  logic [IDX_W-1:0] i_start,
  output logic [IDX_W-1:0] o_win,
  output logic             o_any
);
  logic [IDX_W-1:0] w_start;
  logic [NREQ-1:0]  w_rot;
  logic [IDX_W:0]   w_off;
  logic [IDX_W:0]   w_sum;
  assign w_start = RR ? i_start : '0;
  assign w_rot = NREQ'({i_valid, i_valid} >> w_start);
  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (w_rot[i]) w_off = (IDX_W + 1)'(i);
  end
  assign w_sum = w_off + {1'b0, w_start};
  assign o_win = IDX_W'((w_sum >= (IDX_W + 1)'(NREQ)) ? w_sum - (IDX_W + 1)'(NREQ) : w_sum);
  assign o_any = |i_valid;
endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares one data-bus port among NREQ requesters with lockable ownership.
// Define DBUS_ARB_RR_EN for round-robin arbitration; default build is fixed priority (index 0 highest).
module dbus_arbiter import dbus_arbiter_pkg::*; #(
  parameter int NREQ = DBUS_ARB_NREQ,
  localparam int IDX_W = $clog2(NREQ)
) (
  input logic          clk,
  input logic          reset,
  dbus_arbiter_if.slave bus
);
`ifdef DBUS_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  arb_state_t       r_state, w_state_nx;
  dbus_req_t        r_req, w_req_nx;
  logic [IDX_W-1:0] r_grant, w_grant_nx;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_nx;
  logic [IDX_W-1:0] w_win;
  logic [NREQ-1:0]  w_valid;
  logic             w_any;
  always_comb
    for (int i = 0; i < NREQ; i++) w_valid[i] = bus.ireqs[i].valid;
  dbus_arb_pick #(.NREQ(NREQ), .RR(RR_EN)) u_pick (
    .i_valid(w_valid),
    .i_start(r_rr_ptr),
    .o_win  (w_win),
    .o_any  (w_any)
  );
  always_comb begin
    w_state_nx = r_state;
    w_req_nx   = r_req;
    w_grant_nx = r_grant;
    w_rr_nx    = r_rr_ptr;
    case (r_state)
      ARB_IDLE: if (w_any) begin
        w_state_nx = ARB_BUSY;
        w_grant_nx = w_win;
        w_req_nx   = bus.ireqs[w_win];
      end
      ARB_BUSY: if (bus.iresp.data_ok) begin
        w_state_nx = bus.ilock[r_grant] ? ARB_HOLD : ARB_IDLE;
        w_rr_nx    = IDX_W'(wrap_inc(int'(r_grant), NREQ));
      end
      ARB_HOLD: begin
        w_state_nx = bus.ireqs[r_grant].valid ? ARB_BUSY : (bus.ilock[r_grant] ? ARB_HOLD : ARB_IDLE);
        w_req_nx   = bus.ireqs[r_grant].valid ? bus.ireqs[r_grant] : r_req;
      end
      default: w_state_nx = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= ARB_IDLE;
      r_req    <= '0;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_req    <= w_req_nx;
      r_grant  <= w_grant_nx;
      r_rr_ptr <= w_rr_nx;
    end
  // outputs decode from registered state so reset clears them without waiting for a clock
  always_comb begin
    bus.oreq = (r_state == ARB_BUSY) ? r_req : '0;
    for (int i = 0; i < NREQ; i++)
      bus.oresps[i] = (r_state == ARB_BUSY && bus.iresp.data_ok && r_grant == IDX_W'(i)) ? bus.iresp : '0;
  end
  assign bus.grant_idx = r_grant;
  assign bus.busy = r_state != ARB_IDLE;
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed scenarios then randomized traffic checked against a transaction-level ownership model.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;
  localparam int NREQ = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errs = 0;
  int checks = 0;
  dbus_arbiter_if #(.NREQ(NREQ)) bus ();
  dbus_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [63:0] a, input logic [63:0] d);
    bus.ireqs[i] = '{valid: 1'b1, addr: a, size: MSIZE8, data: d, strobe: 8'hff};
  endtask

  task automatic finish_txn(input int i, input logic [63:0] d, input string tag);
    bus.iresp = '{data_ok: 1'b1, data: d};
    @(negedge clk);
    chk({tag, "_rsp"}, bus.oresps[i], {1'b1, d});
    for (int j = 0; j < NREQ; j++)
      if (j != i) chk({tag, "_other"}, bus.oresps[j], 0);
    tick();
    bus.iresp = '0;
    bus.ireqs[i].valid = 1'b0;
  endtask

  function automatic dbus_req_t rnd_req();
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = {$urandom, $urandom};
    r.size   = msize_t'($urandom_range(0, 3));
    r.data   = {$urandom, $urandom};
    r.strobe = 8'($urandom);
    return r;
  endfunction

  int m_mode, m_own, m_ptr;
  dbus_req_t m_lat;

  function automatic int pick(input int base);
    for (int k = 0; k < NREQ; k++)
      if (bus.ireqs[(base + k) % NREQ].valid) return (base + k) % NREQ;
    return -1;
  endfunction

  initial begin
    int first, second, w, done;
    dbus_req_t exp_req;
    dbus_resp_t exp_rsp;
    for (int i = 0; i < NREQ; i++) bus.ireqs[i] = '0;
    bus.ilock = '0;
    bus.iresp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oreq", bus.oreq, 0);
    chk("rst_grant", bus.grant_idx, 0);
    chk("rst_busy", bus.busy, 0);
    for (int i = 0; i < NREQ; i++) chk("rst_rsp", bus.oresps[i], 0);
    reset = 1'b1;
    // single requester load
    put(ARB_MEM, 64'h8000_0010, 64'h0);
    @(negedge clk);
    chk("t1_not_yet", bus.oreq.valid, 0);
    tick();
    @(negedge clk);
    chk("t1_valid", bus.oreq.valid, 1);
    chk("t1_addr", bus.oreq.addr, 64'h8000_0010);
    chk("t1_size", bus.oreq.size, MSIZE8);
    chk("t1_grant", bus.grant_idx, 0);
    tick();
    @(negedge clk);
    chk("t1_hold_valid", bus.oreq.valid, 1);
    chk("t1_no_ok", bus.oresps[0], 0);
    tick();
    finish_txn(0, 64'hDEAD_BEEF, "t1");
    @(negedge clk);
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_valid", bus.oreq.valid, 0);
    // contention between 0 and 2, rr pointer now 1
`ifdef DBUS_ARB_RR_EN
    first = 2; second = 0;
`else
    first = 0; second = 2;
`endif
    tick();
    put(0, 64'h1000, 64'h10);
    put(2, 64'h2000, 64'h20);
    tick();
    @(negedge clk);
    chk("t2_first_grant", bus.grant_idx, first);
    chk("t2_first_addr", bus.oreq.addr, first == 0 ? 64'h1000 : 64'h2000);
    tick();
    finish_txn(first, 64'h1111, "t2a");
    @(negedge clk);
    chk("t2_turnaround", bus.oreq.valid, 0);
    tick();
    @(negedge clk);
    chk("t2_second_grant", bus.grant_idx, second);
    chk("t2_second_addr", bus.oreq.addr, second == 0 ? 64'h1000 : 64'h2000);
    tick();
    finish_txn(second, 64'h2222, "t2b");
    // locked AMO read then write while requester 1 waits
    bus.ilock[0] = 1'b1;
    put(0, 64'h100, 64'h0);
    tick();
    put(1, 64'h200, 64'h77);
    @(negedge clk);
    chk("t3_rd_grant", bus.grant_idx, 0);
    chk("t3_rd_addr", bus.oreq.addr, 64'h100);
    tick();
    finish_txn(0, 64'hAAAA, "t3rd");
    @(negedge clk);
    chk("t3_hold_busy", bus.busy, 1);
    chk("t3_hold_valid", bus.oreq.valid, 0);
    chk("t3_hold_grant", bus.grant_idx, 0);
    tick();
    put(0, 64'h100, 64'h55);
    @(negedge clk);
    chk("t3_hold2_valid", bus.oreq.valid, 0);
    tick();
    @(negedge clk);
    chk("t3_wr_grant", bus.grant_idx, 0);
    chk("t3_wr_addr", bus.oreq.addr, 64'h100);
    chk("t3_wr_data", bus.oreq.data, 64'h55);
    tick();
    finish_txn(0, 64'hBBBB, "t3wr");
    bus.ilock[0] = 1'b0;
    @(negedge clk);
    chk("t3_hold3_busy", bus.busy, 1);
    chk("t3_hold3_grant", bus.grant_idx, 0);
    tick();
    @(negedge clk);
    chk("t3_exit_busy", bus.busy, 0);
    chk("t3_exit_valid", bus.oreq.valid, 0);
    tick();
    @(negedge clk);
    chk("t3_r1_grant", bus.grant_idx, 1);
    chk("t3_r1_addr", bus.oreq.addr, 64'h200);
    bus.ireqs[1].addr = 64'h300;
    tick();
    @(negedge clk);
    chk("t4_stable_addr", bus.oreq.addr, 64'h200);
    tick();
    finish_txn(1, 64'hCCCC, "t4");
    // reset in the middle of a transaction
    put(2, 64'h400, 64'h44);
    tick();
    @(negedge clk);
    chk("t5_grant", bus.grant_idx, 2);
    tick();
    bus.iresp = '{data_ok: 1'b1, data: 64'h99};
    #1;
    chk("t5_ok_before", bus.oresps[2].data_ok, 1);
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", bus.oreq.valid, 0);
    chk("t5_rst_ok", bus.oresps[2].data_ok, 0);
    chk("t5_rst_busy", bus.busy, 0);
    tick();
    bus.iresp = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rel_idle", bus.oreq.valid, 0);
    tick();
    @(negedge clk);
    chk("t5_rearb_valid", bus.oreq.valid, 1);
    chk("t5_rearb_addr", bus.oreq.addr, 64'h400);
    tick();
    finish_txn(2, 64'hDDDD, "t5");
    // randomized traffic against the ownership model
    for (int i = 0; i < NREQ; i++) bus.ireqs[i] = '0;
    bus.ilock = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_mode = 0; m_own = 0; m_ptr = 0; m_lat = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.ireqs[i].valid && $urandom_range(0, 2) == 0) bus.ireqs[i] = rnd_req();
        if ($urandom_range(0, 4) == 0) bus.ilock[i] = ~bus.ilock[i];
      end
      bus.iresp = '{data_ok: ($urandom_range(0, 2) == 0), data: {$urandom, $urandom}};
      @(negedge clk);
      exp_req = (m_mode == 1) ? m_lat : '0;
      chk("rnd_oreq", bus.oreq, exp_req);
      chk("rnd_grant", bus.grant_idx, m_own);
      chk("rnd_busy", bus.busy, m_mode != 0);
      for (int i = 0; i < NREQ; i++) begin
        exp_rsp = (m_mode == 1 && bus.iresp.data_ok && i == m_own) ? bus.iresp : '0;
        chk("rnd_rsp", bus.oresps[i], exp_rsp);
      end
      done = -1;
      if (m_mode == 0) begin
`ifdef DBUS_ARB_RR_EN
        w = pick(m_ptr);
`else
        w = pick(0);
`endif
        if (w >= 0) begin
          m_own = w; m_lat = bus.ireqs[w]; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (bus.iresp.data_ok) begin
          done = m_own;
          m_ptr = (m_own + 1) % NREQ;
          m_mode = bus.ilock[m_own] ? 2 : 0;
        end
      end else if (bus.ireqs[m_own].valid) begin
        m_lat = bus.ireqs[m_own]; m_mode = 1;
      end else if (!bus.ilock[m_own]) m_mode = 0;
      tick();
      if (done >= 0) begin
        if ($urandom_range(0, 1) == 1) bus.ireqs[done] = rnd_req();
        else bus.ireqs[done].valid = 1'b0;
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
